pll_reset_ce_gen: RTL and testbench



---
 rtl/pll_reset_pkg.sv | 25 ++
 rtl/pll_reset_ce_gen_sync_bit.sv | 28 ++
 rtl/pll_reset_ce_gen.sv | 149 ++++++++++++++
 tb/tb_pll_reset_ce_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared constants, FSM state codes and counter sizing
// for the PLL reset / clock-enable generator.
package pll_reset_pkg;

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_STABLE    = 2'd1;
  localparam logic [1:0] S_HOLD      = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_STABLE = 1024;
  localparam int DEF_RESET_HOLD  = 256;
  localparam int DEF_CE_PIX_DIV  = 8;
  localparam int DEF_CE_CPU_DIV  = 32;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_ce_gen_sync_bit.sv
// Multi-flop synchroniser for one asynchronous level,
// cleared to 0 by the asynchronous reset.
module sync_bit
  import pll_reset_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr_q;
  logic [STAGES-1:0] sr_d;

  always_comb begin
    sr_d = {sr_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q[STAGES-1];

endmodule

// File: rtl/pll_reset_ce_gen.sv
// Qualifies PLL lock and soft reset into a stretched system
// reset, and derives pixel/CPU clock enables while running.
module pll_reset_ce_gen
  import pll_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE,
  parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD,
  parameter int CE_PIX_DIV         = DEF_CE_PIX_DIV,
  parameter int CE_CPU_DIV         = DEF_CE_CPU_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_rst,
  output logic sys_rst,
  output logic ce_pix,
  output logic ce_cpu,
  output logic running
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES,
                                RESET_HOLD_CYCLES);
  localparam int PW = $clog2(CE_PIX_DIV);
  localparam int QW = $clog2(CE_CPU_DIV);

  localparam logic [CW-1:0] LOCK_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(CE_PIX_DIV - 1);
  localparam logic [QW-1:0] CPU_LAST = QW'(CE_CPU_DIV - 1);

  logic lock_s;
  logic srst_s;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_srst_sync (
    .clk (clk),
    .rst (rst),
    .d   (soft_rst),
    .q   (srst_s)
  );

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [QW-1:0] cpu_q, cpu_d;
  logic          sys_rst_q, sys_rst_d;
  logic          running_q, running_d;
  logic          ce_pix_q, ce_pix_d;
  logic          ce_cpu_q, ce_cpu_d;
  logic          run_now;
  logic          run_next;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) state_d = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (srst_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (srst_s) begin
          state_d = S_HOLD;
        end
      end
    endcase
  end

  // Dividers restart from zero on every RUN entry so the
  // first enable always lands a full period into RUN.
  always_comb begin
    run_now  = (state_q == S_RUN);
    run_next = (state_d == S_RUN);
    pix_d    = '0;
    cpu_d    = '0;
    if (run_next && run_now) begin
      pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + PW'(1);
      cpu_d = (cpu_q == CPU_LAST) ? '0 : cpu_q + QW'(1);
    end
    sys_rst_d = !run_next;
    running_d = run_next;
    ce_pix_d  = run_next && (pix_d == PIX_LAST);
    ce_cpu_d  = run_next && (cpu_d == CPU_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_WAIT_LOCK;
      cnt_q     <= '0;
      pix_q     <= '0;
      cpu_q     <= '0;
      sys_rst_q <= 1'b1;
      running_q <= 1'b0;
      ce_pix_q  <= 1'b0;
      ce_cpu_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pix_q     <= pix_d;
      cpu_q     <= cpu_d;
      sys_rst_q <= sys_rst_d;
      running_q <= running_d;
      ce_pix_q  <= ce_pix_d;
      ce_cpu_q  <= ce_cpu_d;
    end
  end

  assign sys_rst = sys_rst_q;
  assign running = running_q;
  assign ce_pix  = ce_pix_q;
  assign ce_cpu  = ce_cpu_q;

endmodule

// File: tb/tb_pll_reset_ce_gen.sv
// Self-checking bench: directed timing scenarios plus
// randomized lock/soft-reset traffic against a timing model.
module tb_pll_reset_ce_gen;

  localparam int SYNC = 2;
  localparam int LOCK = 4;
  localparam int HOLD = 3;
  localparam int PIX  = 8;
  localparam int CPU  = 32;

  logic clk = 1'b0;
  logic rst;
  logic pll_locked;
  logic soft_rst;
  logic sys_rst;
  logic ce_pix;
  logic ce_cpu;
  logic running;

  always #5 clk = ~clk;

  pll_reset_ce_gen #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (LOCK),
    .RESET_HOLD_CYCLES  (HOLD),
    .CE_PIX_DIV         (PIX),
    .CE_CPU_DIV         (CPU)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .soft_rst   (soft_rst),
    .sys_rst    (sys_rst),
    .ce_pix     (ce_pix),
    .ce_cpu     (ce_cpu),
    .running    (running)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Timing model: inputs seen through a SYNC-deep delay,
  // run state derived from lock streak length and the
  // age of the last soft reset accepted after qualification.
  bit ld[$];
  bit sd[$];
  int edge_no;
  int lock_len;
  int last_srst;
  int run_len;
  bit m_run;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t",
                  tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    ld = {};
    sd = {};
    for (int i = 0; i < SYNC; i++) begin
      ld.push_back(1'b0);
      sd.push_back(1'b0);
    end
    edge_no   = 0;
    lock_len  = 0;
    last_srst = -1000;
    run_len   = 0;
    m_run     = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    bit ss;
    ls = ld.pop_front();
    ss = sd.pop_front();
    ld.push_back(pll_locked);
    sd.push_back(soft_rst);
    edge_no++;
    lock_len = ls ? lock_len + 1 : 0;
    if (ls && ss && lock_len >= 2 + LOCK)
      last_srst = edge_no;
    m_run = ls && (lock_len >= 1 + LOCK + HOLD)
            && (edge_no - last_srst >= HOLD);
    run_len = m_run ? run_len + 1 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check("sys_rst", 32'(sys_rst), 32'(!m_run));
    check("running", 32'(running), 32'(m_run));
    check("ce_pix", 32'(ce_pix),
          32'(m_run && (run_len % PIX == 0)));
    check("ce_cpu", 32'(ce_cpu),
          32'(m_run && (run_len % CPU == 0)));
  endtask

  // Raise lock (already driven) and time the first
  // sys_rst fall, ce_pix and ce_cpu in edges.
  task automatic time_bringup(
    input  int n,
    output int t_fall,
    output int t_pix,
    output int t_cpu
  );
    t_fall = -1;
    t_pix  = -1;
    t_cpu  = -1;
    for (int i = 1; i <= n; i++) begin
      step();
      if (t_fall < 0 && !sys_rst) t_fall = i;
      if (t_pix < 0 && ce_pix)    t_pix  = i;
      if (t_cpu < 0 && ce_cpu)    t_cpu  = i;
    end
  endtask

  int t_fall, t_pix, t_cpu, t_hi, n_hi, dl;

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    soft_rst   = 1'b0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;

    repeat (50) step();

    pll_locked = 1'b1;
    time_bringup(60, t_fall, t_pix, t_cpu);
    check("bringup_fall", t_fall, 10);
    check("bringup_pix", t_pix, 17);
    check("bringup_cpu", t_cpu, 41);

    // single-cycle lock drop while running
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    t_hi   = -1;
    t_fall = -1;
    for (int i = 2; i <= 40; i++) begin
      step();
      if (t_hi < 0 && sys_rst) t_hi = i;
      if (t_hi > 0 && t_fall < 0 && !sys_rst) t_fall = i;
    end
    check("drop_rst_hi", t_hi, 3);
    check("drop_reenter", t_fall, 11);

    // glitch during STABLE with cnt at 2
    pll_locked = 1'b0;
    repeat (10) step();
    pll_locked = 1'b1;
    repeat (3) step();
    pll_locked = 1'b0;
    repeat (3) step();
    pll_locked = 1'b1;
    t_fall = -1;
    for (int i = 7; i <= 40; i++) begin
      step();
      if (t_fall < 0 && !sys_rst) t_fall = i;
    end
    check("glitch_fall", t_fall, 16);

    // soft reset pulse while running
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
    n_hi  = 0;
    t_pix = -1;
    for (int i = 2; i <= 30; i++) begin
      step();
      if (sys_rst) n_hi++;
      if (n_hi > 0 && t_pix < 0 && ce_pix) t_pix = i;
    end
    check("srst_hold_len", n_hi, 3);
    check("srst_first_pix", t_pix, 13);

    // asynchronous reset mid-run
    #2 rst = 1'b1;
    #1;
    check("arst_sys_rst", 32'(sys_rst), 32'd1);
    check("arst_running", 32'(running), 32'd0);
    check("arst_ce_pix", 32'(ce_pix), 32'd0);
    check("arst_ce_cpu", 32'(ce_cpu), 32'd0);
    @(negedge clk);
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    time_bringup(45, t_fall, t_pix, t_cpu);
    check("arst_refall", t_fall, 10);
    check("arst_repix", t_pix, 17);
    check("arst_recpu", t_cpu, 41);

    // randomized lock drops and soft reset pulses
    dl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (dl > 0) begin
        dl--;
        pll_locked = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        dl = $urandom_range(0, 5);
        pll_locked = 1'b0;
      end else begin
        pll_locked = 1'b1;
      end
      soft_rst = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
